// File: rtl/kt8_pkg.sv
// kt8_pkg: shared types and constants for the KT8 program loader.
// Holds the loader state encoding and default widths.
package kt8_pkg;

  localparam int PADDR_W = 8;
  localparam int INSTR_W = 8;

  // A length byte of zero selects a full-depth load.
  localparam bit LEN_ZERO_MEANS_FULL = 1'b1;

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_DATA = 2'd1,
    S_CHK  = 2'd2,
    S_RUN  = 2'd3
  } ld_state_e;

endpackage

// File: rtl/kt8_prog_ram.sv
// kt8_prog_ram: program store, one synchronous write port and
// one asynchronous read port; contents are never reset.
module kt8_prog_ram #(
  parameter int PADDR_W = kt8_pkg::PADDR_W,
  parameter int INSTR_W = kt8_pkg::INSTR_W
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [PADDR_W-1:0] waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [PADDR_W-1:0] raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << PADDR_W;

  logic [INSTR_W-1:0] mem_q [DEPTH];

  // Write port: one byte per enabled edge.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/kt8_prog_loader.sv
// kt8_prog_loader: KT8 program store front-end and boot loader.
// Build option: define KT8_LOAD_CHECKSUM_EN to require a trailing checksum byte.
module kt8_prog_loader #(
  parameter int PADDR_W = kt8_pkg::PADDR_W,
  parameter int INSTR_W = kt8_pkg::INSTR_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [PADDR_W-1:0] p_address_i,
  output logic [INSTR_W-1:0] p_data_o,
  input  logic [INSTR_W-1:0] ld_data_i,
  input  logic               ld_valid_i,
  output logic               ld_ready_o,
  input  logic               ld_start_i,
  output logic               cpu_rst_o,
  output logic               ld_done_o,
  output logic               ld_err_o
);

  import kt8_pkg::ld_state_e;
  import kt8_pkg::S_LEN;
  import kt8_pkg::S_DATA;
  import kt8_pkg::S_CHK;
  import kt8_pkg::S_RUN;
  import kt8_pkg::LEN_ZERO_MEANS_FULL;

  // One extra bit so a 256-byte length is representable.
  localparam int CNT_W = PADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = {1'b1, {PADDR_W{1'b0}}};

  ld_state_e state_q, state_d;

  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] addr_q, addr_d;
  logic             done_q, done_d;
  logic             xfer;
  logic             last_byte;
  logic             wr_en;

  assign xfer      = ld_valid_i && ld_ready_o;
  assign last_byte = (addr_q == len_q - CNT_W'(1));

`ifdef KT8_LOAD_CHECKSUM_EN
  logic [INSTR_W-1:0] sum_q, sum_d;
  logic [INSTR_W-1:0] chk_sum;
  logic               err_q, err_d;
  logic               sum_ok;

  assign chk_sum = sum_q + ld_data_i;
  assign sum_ok  = (chk_sum == '0);

  // Checksum accumulator and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  // Sum data bytes; error sets on a bad check byte, clears on a new length.
  always_comb begin
    sum_d = sum_q;
    err_d = err_q;
    if (ld_start_i) begin
      sum_d = '0;
    end else if (xfer) begin
      unique case (state_q)
        S_LEN: begin
          sum_d = '0;
          err_d = 1'b0;
        end
        S_DATA: sum_d = chk_sum;
        S_CHK: begin
          if (!sum_ok) begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ld_err_o = err_q;
`else
  assign ld_err_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_LEN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a start request overrides everything.
  always_comb begin
    state_d = state_q;
    if (ld_start_i) begin
      state_d = S_LEN;
    end else if (xfer) begin
      unique case (state_q)
        S_LEN: state_d = S_DATA;
        S_DATA: begin
          if (last_byte) begin
`ifdef KT8_LOAD_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_RUN;
`endif
          end
        end
`ifdef KT8_LOAD_CHECKSUM_EN
        S_CHK: state_d = sum_ok ? S_RUN : S_LEN;
`endif
        default: ;
      endcase
    end
  end

  // Outputs: handshake, CPU reset hold and store write strobe.
  always_comb begin
    ld_ready_o = (state_q != S_RUN) && !ld_start_i;
    cpu_rst_o  = (state_q != S_RUN);
    wr_en      = xfer && (state_q == S_DATA);
    ld_done_o  = done_q;
  end

  // Length, address counter and done pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_q  <= '0;
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      len_q  <= len_d;
      addr_q <= addr_d;
      done_q <= done_d;
    end
  end

  // Latch length, step the write address, flag the accepting transfer.
  always_comb begin
    len_d  = len_q;
    addr_d = addr_q;
    done_d = 1'b0;
    if (ld_start_i) begin
      addr_d = '0;
    end else if (xfer) begin
      unique case (state_q)
        S_LEN: begin
          addr_d = '0;
          if (LEN_ZERO_MEANS_FULL && ld_data_i == '0) begin
            len_d = DEPTH;
          end else begin
            len_d = CNT_W'(ld_data_i);
          end
        end
        S_DATA: begin
          addr_d = addr_q + CNT_W'(1);
`ifndef KT8_LOAD_CHECKSUM_EN
          done_d = last_byte;
`endif
        end
`ifdef KT8_LOAD_CHECKSUM_EN
        S_CHK: done_d = sum_ok;
`endif
        default: ;
      endcase
    end
  end

  kt8_prog_ram #(
    .PADDR_W (PADDR_W),
    .INSTR_W (INSTR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (addr_q[PADDR_W-1:0]),
    .wdata_i (ld_data_i),
    .raddr_i (p_address_i),
    .rdata_o (p_data_o)
  );

endmodule

// File: doc/kt8_prog_loader.md
Name: kt8_prog_loader

Overview:
- Program-memory responder and boot loader for the KT8 CPU core.
- Owns the 256x8 program store.
- Answers the CPU instruction-fetch interface: PC address in, instruction byte out, same cycle.
- Accepts a length-prefixed, checksummed byte stream over a valid/ready port and holds the CPU in reset until a load completes.

Parameters:
- PADDR_W, 8, program address width; store depth is 2**PADDR_W.
- INSTR_W, 8, instruction/load byte width.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- p_address_i  in  PADDR_W  instruction fetch address from the CPU PC.
- p_data_o  out  INSTR_W  instruction byte to the CPU.
- ld_data_i  in  INSTR_W  load stream byte.
- ld_valid_i  in  1  load byte valid.
- ld_ready_o  out  1  loader can accept a byte.
- ld_start_i  in  1  request a (re)load; one-cycle level sample.
- cpu_rst_o  out  1  CPU reset request; combine with system reset at top.
- ld_done_o  out  1  one-cycle pulse when a load is accepted.
- ld_err_o  out  1  sticky checksum-error flag.

Behaviour:
- One clock domain. Synchronous, active-high reset.
- Reset puts the FSM in S_LEN and clears the address counter and the checksum accumulator. It does not clear store contents.
- Reset output values: cpu_rst_o=1, ld_done_o=0, ld_err_o=0. ld_ready_o=1 unless ld_start_i is high.
- Read path:
  - p_data_o = mem[p_address_i], asynchronous read with zero latency.
  - The read is valid in every state.
  - A write to the addressed location is visible on p_data_o the cycle after the write edge.
- Transfer rule: a byte transfers on a rising edge where ld_valid_i and ld_ready_o are both 1.
- ld_ready_o = (state != S_RUN) and not ld_start_i. This is combinational from ld_start_i.
- S_LEN:
  - The transferred byte gives length N; 0 means 256.
  - Clear the address counter and the checksum, clear ld_err_o, then go to S_DATA.
- S_DATA:
  - Each transferred byte is written to mem[addr] and added mod 256 to the checksum; addr then increments.
  - After the Nth byte, go to S_CHK.
  - The address counter never wraps to write location 0 a second time.
  - Locations at or above N keep their previous contents.
- S_CHK:
  - Transferred byte C. If (sum + C) mod 256 == 0, go to S_RUN, and on the next cycle ld_done_o=1 for exactly one cycle with cpu_rst_o=0.
  - Otherwise set ld_err_o=1 and return to S_LEN; cpu_rst_o stays 1.
- S_RUN:
  - cpu_rst_o=0 and ld_ready_o=0.
  - ld_valid_i is ignored.
- ld_start_i in any state:
  - Next state is S_LEN, the address counter and checksum are cleared, and cpu_rst_o=1 from the next cycle.
  - Any byte offered in the same cycle is not transferred, because ready is low.
  - Partial writes already made remain in the store.
- rst_i mid-load behaves like reset and also clears ld_err_o.

Optional Feature:
- KT8_LOAD_CHECKSUM_EN defined: S_CHK exists and ld_err_o behaves as described above.
- KT8_LOAD_CHECKSUM_EN undefined: no checksum byte is sent. S_DATA goes directly to S_RUN after the Nth byte, ld_done_o pulses the following cycle, and ld_err_o is tied to 0.

Decomposition:
- Package kt8_pkg holds:
  - the state enum typedef: S_LEN, S_DATA, S_CHK, S_RUN;
  - the constants PADDR_W=8 and INSTR_W=8;
  - the constant LEN_ZERO_MEANS_FULL.
- One sub-module, kt8_prog_ram: 2**PADDR_W x INSTR_W store, synchronous write port, asynchronous read port.
- The FSM, counter and checksum stay in kt8_prog_loader.

Test Plan:
- Load with checksum:
  - Stimulus: after reset, stream 03, A1, B2, C3, EA.
  - Response: ld_done_o pulses once and cpu_rst_o falls the same cycle. p_address_i=00/01/02 returns A1/B2/C3, and ld_ready_o=0 afterwards.
- Bad checksum:
  - Stimulus: stream 02, 11, 22, 00.
  - Response: ld_err_o=1, cpu_rst_o stays 1, ld_ready_o=1, no ld_done_o.
  - Follow-up: next stream 01, 5A, A6 clears ld_err_o at the length byte and completes the load.
- Full-depth load:
  - Stimulus: length 00 followed by 256 bytes (value = address) and the correct checksum 80.
  - Response: mem[FF]=FF, mem[00]=00, exactly 256 writes, then done.
- Restart mid-load:
  - Stimulus: load 03, 01, 02, 03, FA (store 01/02/03, run). Then ld_start_i, stream 03, 77, 88, then pulse ld_start_i with ld_valid_i=1.
  - Response: ld_ready_o=0 that cycle and the byte is not taken. Then 01, 55, AB gives mem[0]=55 and mem[1]=88 (partial write retained).
- Backpressure and reset:
  - Stimulus: toggle ld_valid_i randomly during a 4-byte load.
  - Response: only valid&&ready bytes advance addr.
  - Stimulus: rst_i asserted after 2 data bytes.
  - Response: S_LEN, cpu_rst_o=1, ld_err_o=0, store contents retained.
- RUN ignores the stream:
  - Stimulus: in S_RUN, hold ld_valid_i=1 with data 99 for 10 cycles.
  - Response: ld_ready_o=0, no writes, cpu_rst_o=0.
